// File: rtl/sram_req_tracker.sv
// sram_req_tracker: request issue and in-flight tracking for an SRAM-like
// req/addr_ok/data_ok bus. Counts accepted-but-unreturned transactions,
// throttles issue at MAX_OUTSTANDING, and discards returns owed to requests
// that were in flight when the pipeline flushed.
module sram_req_tracker #(
    parameter int MAX_OUTSTANDING = 2,  // >= 1
    parameter int CNT_W           = 2   // 2**CNT_W > MAX_OUTSTANDING
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stage_req,
    input  logic             flush,
    input  logic             addr_ok,
    input  logic             data_ok,
    output logic             sram_req,
    output logic             data_valid,
    output logic [CNT_W-1:0] outstanding,
    output logic [CNT_W-1:0] discard_pend,
    output logic             full,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             proto_err_q, proto_err_d;

    logic can_issue;
    logic acc;
    logic ret;
    logic spurious;

    // Derive issue, accept/return events and the next value of every register.
    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        proto_err_d   = proto_err_q;

        // Issue depends only on the registered state: a slot freed by a return
        // becomes usable on the following cycle, never the same one.
        can_issue = (state_q != ST_FULL) && !flush;
        sram_req  = stage_req && can_issue && resetn;
        acc       = sram_req && addr_ok;
        ret       = data_ok && (outstanding_q != '0);
        spurious  = data_ok && (outstanding_q == '0);

        // A return only belongs to a live request when no older flush still
        // owes garbage returns and this cycle is not itself a flush.
        data_valid = ret && !flush && (discard_q == '0) && resetn;

        outstanding_d = outstanding_q + CNT_W'(acc) - CNT_W'(ret);

        // A flush marks everything still in flight (after this cycle's return)
        // as garbage; this overrides any count left from an earlier flush,
        // which is always a subset of what is in flight now.
        if (flush) begin
            discard_d = outstanding_q - CNT_W'(ret);
        end else if (ret && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        if (spurious) begin
            proto_err_d = 1'b1;
        end

        if (outstanding_d == '0) begin
            state_d = ST_IDLE;
        end else if (outstanding_d == MAX_CNT) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_BUSY;
        end
    end

    // State, counters and sticky error, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q       <= ST_IDLE;
            outstanding_q <= '0;
            discard_q     <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign outstanding  = outstanding_q;
    assign discard_pend = discard_q;
    assign full         = (state_q == ST_FULL);
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_sram_req_tracker.sv
// Testbench for sram_req_tracker (MAX_OUTSTANDING=2). Stimulus pushes the
// expected data_valid of every bus return into a queue; a monitor pops and
// compares on each return it sees. Counter/flag expectations are checked
// directly by the stimulus against hand-computed values.
module tb_sram_req_tracker;

    localparam int MAX_OUTSTANDING = 2;
    localparam int CNT_W           = 2;

    logic             clk;
    logic             resetn;
    logic             stage_req;
    logic             flush;
    logic             addr_ok;
    logic             data_ok;
    logic             sram_req;
    logic             data_valid;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard_pend;
    logic             full;
    logic             proto_err;

    int checks   = 0;
    int failures = 0;

    bit exp_dv_q[$];

    sram_req_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stage_req   (stage_req),
        .flush       (flush),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .sram_req    (sram_req),
        .data_valid  (data_valid),
        .outstanding (outstanding),
        .discard_pend(discard_pend),
        .full        (full),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every return presented outside reset is matched to the
    // oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && data_ok) begin
            if (exp_dv_q.size() == 0) begin
                check("unexpected_return", 1, 0);
            end else begin
                check("data_valid", int'(data_valid), int'(exp_dv_q.pop_front()));
            end
        end
    end

    // Apply one cycle's inputs just after a rising edge; record expectation.
    task automatic drive(input bit sr, input bit fl, input bit ao, input bit dok, input bit exp_dv);
        stage_req = sr;
        flush     = fl;
        addr_ok   = ao;
        data_ok   = dok;
        if (dok && resetn) exp_dv_q.push_back(exp_dv);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_regs(input string tag, input int exp_out, input int exp_disc,
                              input int exp_full, input int exp_perr);
        check({tag, ".outstanding"}, int'(outstanding), exp_out);
        check({tag, ".discard_pend"}, int'(discard_pend), exp_disc);
        check({tag, ".full"}, int'(full), exp_full);
        check({tag, ".proto_err"}, int'(proto_err), exp_perr);
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // 1: reset held two cycles with stage_req high
        check("reset.sram_req_pre", int'(sram_req), 0);
        tick();
        tick();
        check("reset.sram_req", int'(sram_req), 0);
        check("reset.data_valid", int'(data_valid), 0);
        check_regs("reset", 0, 0, 0, 0);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // 2: single transaction
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single.sram_req", int'(sram_req), 1);
        tick();
        check_regs("single.t1", 1, 0, 0, 0);
        idle();
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_regs("single.t4", 0, 0, 0, 0);

        // 3: fill to MAX, throttle, slot frees the cycle after the return
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_regs("fill.t2", 2, 0, 1, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fill.t2.sram_req", int'(sram_req), 0);
        tick();
        check_regs("fill.t3", 2, 0, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("fill.t4.no_bypass", int'(sram_req), 0);
        tick();
        check_regs("fill.t5", 1, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fill.t5.sram_req", int'(sram_req), 1);
        tick();

        // 4: simultaneous accept and return at outstanding=1
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("simul.sram_req", int'(sram_req), 1);
        tick();
        check_regs("simul", 1, 0, 0, 0);

        // 5: flush with two in flight, both returns dropped, next one live
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_regs("flush.pre", 2, 0, 1, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flush.sram_req", int'(sram_req), 0);
        tick();
        check_regs("flush.t1", 2, 2, 1, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("flush.ret1", 1, 1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("flush.ret2", 0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_regs("flush.live", 0, 0, 0, 0);

        // 5b: flush coinciding with a return: discard = outstanding - 1
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("flushret", 1, 1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("flushret.drain", 0, 0, 0, 0);

        // 6: spurious return sets sticky proto_err
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("spur", 0, 0, 0, 1);
        idle();
        idle();
        check("spur.sticky", int'(proto_err), 1);

        // Reset mid-operation clears counts; later return is spurious
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("midrst.pre", int'(outstanding), 1);
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_regs("midrst", 0, 0, 0, 0);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_regs("midrst.late", 0, 0, 0, 1);
        idle();

        check("queue_drained", exp_dv_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
